audio_mix_sat: RTL

Parametrised, time-multiplexed audio mixer for the emulated-system top level. It snapshots NUM_CH source channels on a sample request and applies per-channel attenuation and signed/unsigned handling. It accumulates one channel per clock and delivers one saturated (or wrapped) OUT_W-bit signed sample with a valid strobe and clip flag. It replaces the fixed three-source combinational mix and lookup-table compressor ahead of AUDIO_L/AUDIO_R.

---
 rtl/audio_mix_sat.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/audio_mix_sat.sv
// Time-multiplexed audio mixer: snapshots NUM_CH channels on request, accumulates one
// attenuated channel per clock, then emits one saturated (or wrapped) signed sample.
module audio_mix_sat #(
   parameter int NUM_CH   = 4,
   parameter int IN_W     = 16,
   parameter int OUT_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     sample_req,
   input  logic [NUM_CH*IN_W-1:0]   ch_data,
   input  logic [NUM_CH-1:0]        ch_unsigned,
   input  logic [NUM_CH*3-1:0]      ch_atten,
   output logic signed [OUT_W-1:0]  audio_out,
   output logic                     out_valid,
   output logic                     clip,
   output logic                     busy,
   output logic                     overrun
);

   localparam int ACC_W = IN_W + 1 + $clog2(NUM_CH);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_SAT  = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [NUM_CH*IN_W-1:0]    data_q, data_d;
   logic [NUM_CH-1:0]         uns_q, uns_d;
   logic [NUM_CH*3-1:0]       atten_q, atten_d;
   logic [OUT_W-1:0]          audio_q, audio_d;
   logic                      valid_q, valid_d;
   logic                      clip_q, clip_d;
   logic                      busy_q, busy_d;
   logic                      overrun_q, overrun_d;

   logic signed [ACC_W-1:0]   term [NUM_CH];
   logic signed [ACC_W-1:0]   term_sel;
   logic                      over_hi, over_lo;

   // Per-channel term from the snapshot: extend to IN_W+1 signed, shift (floor), or mute.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_term
         logic [2:0]          att;
         logic signed [IN_W:0] ext;
         logic signed [IN_W:0] shifted;
         assign att     = atten_q[gi*3 +: 3];
         assign ext     = uns_q[gi] ? $signed({1'b0, data_q[gi*IN_W +: IN_W]})
                                    : $signed({data_q[gi*IN_W+IN_W-1], data_q[gi*IN_W +: IN_W]});
         assign shifted = ext >>> att;
         assign term[gi] = (att == 3'd7) ? '0 : ACC_W'(shifted);
      end
   endgenerate

   assign term_sel = term[idx_q];
   assign over_hi  = acc_q > OUT_MAX;
   assign over_lo  = acc_q < OUT_MIN;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      data_d    = data_q;
      uns_d     = uns_q;
      atten_d   = atten_q;
      audio_d   = audio_q;
      clip_d    = clip_q;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sample_req) begin
               data_d  = ch_data;
               uns_d   = ch_unsigned;
               atten_d = ch_atten;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            overrun_d = sample_req;
            acc_d     = acc_q + term_sel;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = S_SAT;
         end
         S_SAT: begin
            overrun_d = sample_req;
            clip_d    = over_hi | over_lo;
            if (SATURATE && over_hi)      audio_d = OUT_MAX[OUT_W-1:0];
            else if (SATURATE && over_lo) audio_d = OUT_MIN[OUT_W-1:0];
            else                          audio_d = acc_q[OUT_W-1:0];
            valid_d   = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Busy stays up through the cycle that presents the result.
      busy_d = (state_d != S_IDLE) || (state_q == S_SAT);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         data_q    <= '0;
         uns_q     <= '0;
         atten_q   <= '0;
         audio_q   <= '0;
         clip_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         data_q    <= data_d;
         uns_q     <= uns_d;
         atten_q   <= atten_d;
         audio_q   <= audio_d;
         clip_q    <= clip_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign audio_out = audio_q;
   assign out_valid = valid_q;
   assign clip      = clip_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule
